// File: rtl/idex_pkg.sv
// Shared types and default widths for the ID/EX pipeline buffer.
package idex_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_CTRL_W  = 16;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    pc;
    logic [DEF_XLEN-1:0]    rs1val;
    logic [DEF_XLEN-1:0]    rs2val;
    logic [DEF_XLEN-1:0]    lsjaddr;
    logic [DEF_XLEN-1:0]    upimm;
    logic [DEF_RADDR_W-1:0] rs1;
    logic [DEF_RADDR_W-1:0] rs2;
    logic [DEF_RADDR_W-1:0] rd;
    logic [DEF_CTRL_W-1:0]  ctrl;
    logic                   is_load;
  } idex_entry_t;

endpackage

// File: rtl/idex_hazard_chk.sv
// Load-use detector: flags an incoming rs1/rs2 that matches the rd of any
// buffered, valid load writing a non-zero register.
module idex_hazard_chk
  import idex_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic [DEPTH-1:0]         entry_valid,
  input  logic [DEPTH-1:0]         entry_load,
  input  logic [DEPTH*RADDR_W-1:0] entry_rd,
  input  logic [RADDR_W-1:0]       rs1,
  input  logic [RADDR_W-1:0]       rs2,
  output logic                     match
);

  logic [RADDR_W-1:0] rd_i;

  always_comb begin
    match = 1'b0;
    rd_i  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_i = entry_rd[i*RADDR_W +: RADDR_W];
      if (entry_valid[i] && entry_load[i] && (rd_i != RADDR_W'(REG_ZERO)) &&
          ((rd_i == rs1) || (rd_i == rs2)))
        match = 1'b1;
    end
  end

endmodule

// File: rtl/idex_pipe_buf.sv
// ID/EX pipeline stage: DEPTH-entry circular buffer with valid/ready on both
// sides, redirect flush and load-use stall. Optional counters: IDEX_BUBBLE_CNT_EN.
module idex_pipe_buf
  import idex_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int DEPTH   = 2
) (
  input  logic                       CLK,
  input  logic                       RSTB,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_rs1val,
  input  logic [XLEN-1:0]            in_rs2val,
  input  logic [XLEN-1:0]            in_lsjaddr,
  input  logic [XLEN-1:0]            in_upimm,
  input  logic [RADDR_W-1:0]         in_rs1,
  input  logic [RADDR_W-1:0]         in_rs2,
  input  logic [RADDR_W-1:0]         in_rd,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       in_is_load,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_rs1val,
  output logic [XLEN-1:0]            out_rs2val,
  output logic [XLEN-1:0]            out_lsjaddr,
  output logic [XLEN-1:0]            out_upimm,
  output logic [RADDR_W-1:0]         out_rd,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic                       out_is_load,
  input  logic                       flush,
  output logic                       hazard_stall,
  output logic [$clog2(DEPTH):0]     occupancy
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [31:0]                bubble_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Source indices are consumed here by the hazard check and not carried on.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1val;
    logic [XLEN-1:0]    rs2val;
    logic [XLEN-1:0]    lsjaddr;
    logic [XLEN-1:0]    upimm;
    logic [RADDR_W-1:0] rd;
    logic [CTRL_W-1:0]  ctrl;
    logic               is_load;
  } entry_t;

  entry_t                   mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;
  logic                     accept;
  logic                     consume;
  logic                     load_match;
  logic [DEPTH-1:0]         entry_valid;
  logic [DEPTH-1:0]         entry_load;
  logic [DEPTH*RADDR_W-1:0] entry_rd;
  logic [PTR_W-1:0]         offset;
  entry_t                   head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    entry_valid = '0;
    entry_load  = '0;
    entry_rd    = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = (CNT_W'(offset) < count);
      entry_load[i]  = mem[i].is_load;
      entry_rd[i*RADDR_W +: RADDR_W] = mem[i].rd;
    end
  end

  idex_hazard_chk #(
    .DEPTH   (DEPTH),
    .RADDR_W (RADDR_W)
  ) u_hazard (
    .entry_valid (entry_valid),
    .entry_load  (entry_load),
    .entry_rd    (entry_rd),
    .rs1         (in_rs1),
    .rs2         (in_rs2),
    .match       (load_match)
  );

  assign hazard_stall = in_valid & load_match & ~flush;
  assign in_ready     = (~full & ~hazard_stall) | flush;
  // A beat offered during flush is acknowledged but never written.
  assign accept       = in_valid & in_ready & ~flush;
  assign out_valid    = ~empty;
  assign consume      = out_valid & out_ready;
  assign occupancy    = count;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (accept)  wr_ptr <= next_ptr(wr_ptr);
      if (consume) rd_ptr <= next_ptr(rd_ptr);
      case ({accept, consume})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[wr_ptr].pc      <= in_pc;
      mem[wr_ptr].rs1val  <= in_rs1val;
      mem[wr_ptr].rs2val  <= in_rs2val;
      mem[wr_ptr].lsjaddr <= in_lsjaddr;
      mem[wr_ptr].upimm   <= in_upimm;
      mem[wr_ptr].rd      <= in_rd;
      mem[wr_ptr].ctrl    <= in_ctrl;
      mem[wr_ptr].is_load <= in_is_load;
    end
  end

  // Stale storage is masked so an empty stage presents all-zero fields.
  assign head        = empty ? '0 : mem[rd_ptr];
  assign out_pc      = head.pc;
  assign out_rs1val  = head.rs1val;
  assign out_rs2val  = head.rs2val;
  assign out_lsjaddr = head.lsjaddr;
  assign out_upimm   = head.upimm;
  assign out_rd      = head.rd;
  assign out_ctrl    = head.ctrl;
  assign out_is_load = head.is_load;

`ifdef IDEX_BUBBLE_CNT_EN
  // Flush is only counted when it actually threw work away.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (hazard_stall && (bubble_cnt != 32'hFFFF_FFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
      if (flush && (in_valid || (count > CNT_W'(consume))))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idex_pipe_buf.sv
// Directed bench for idex_pipe_buf: DEPTH=2 instance for handshake, hazard,
// flush and reset cases; DEPTH=4 instance for wrap-around traffic.
module tb_idex_pipe_buf;

  logic        CLK = 1'b0;
  logic        RSTB;
  logic        in_valid, in_ready, in_is_load, out_valid, out_ready, flush;
  logic        hazard_stall, out_is_load;
  logic [31:0] in_pc, in_rs1val, out_pc, out_rs1val, out_rs2val, out_lsjaddr, out_upimm;
  logic [4:0]  in_rs1, in_rs2, in_rd, out_rd;
  logic [15:0] in_ctrl, out_ctrl;
  logic [1:0]  occupancy;

  logic        v4, ready4, valid4, ordy4, hz4, ld4;
  logic [31:0] pc4, opc4, o4_rs1val, o4_rs2val, o4_lsj, o4_up;
  logic [4:0]  o4_rd;
  logic [15:0] o4_ctrl;
  logic [2:0]  occ4;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt, bubble4, flush4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  idex_pipe_buf #(.DEPTH(2)) u_dut (
    .CLK(CLK), .RSTB(RSTB),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1val(in_rs1val), .in_rs2val(in_pc + 32'h1), .in_lsjaddr(in_pc + 32'h2),
    .in_upimm(in_pc + 32'h3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_ctrl(in_ctrl), .in_is_load(in_is_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1val(out_rs1val), .out_rs2val(out_rs2val), .out_lsjaddr(out_lsjaddr),
    .out_upimm(out_upimm), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .out_is_load(out_is_load), .flush(flush), .hazard_stall(hazard_stall),
    .occupancy(occupancy)
`ifdef IDEX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  idex_pipe_buf #(.DEPTH(4)) u_dut4 (
    .CLK(CLK), .RSTB(RSTB),
    .in_valid(v4), .in_ready(ready4), .in_pc(pc4),
    .in_rs1val(~pc4), .in_rs2val(32'h0), .in_lsjaddr(32'h0), .in_upimm(32'h0),
    .in_rs1(5'd0), .in_rs2(5'd0), .in_rd(5'd0), .in_ctrl(16'h0), .in_is_load(1'b0),
    .out_valid(valid4), .out_ready(ordy4), .out_pc(opc4),
    .out_rs1val(o4_rs1val), .out_rs2val(o4_rs2val), .out_lsjaddr(o4_lsj),
    .out_upimm(o4_up), .out_rd(o4_rd), .out_ctrl(o4_ctrl),
    .out_is_load(ld4), .flush(1'b0), .hazard_stall(hz4), .occupancy(occ4)
`ifdef IDEX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble4), .flush_cnt(flush4)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic ld,
                                input logic ordy, input logic fl);
    in_valid   = v;
    in_pc      = pc;
    in_rs1val  = pc ^ 32'hBA;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_is_load = ld;
    in_ctrl    = pc[15:0] ^ 16'h1200;
    out_ready  = ordy;
    flush      = fl;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int q[$];
    int sent;
    int got;
    int cyc;
    logic hs_in;

    RSTB = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    v4 = 0; pc4 = 0; ordy4 = 0;
    #22;
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_occupancy", 32'(occupancy), 0);
    check_output("rst_out_pc", out_pc, 0);
    RSTB = 1'b1;
    step();

    // single beat, pc 0x10 -> rs1val 0x10^0xBA = 0xAA
    apply_stimulus(1, 32'h10, 0, 0, 5'd3, 0, 1, 0);
    #1 check_output("t1_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    check_output("t1_out_valid", 32'(out_valid), 1);
    check_output("t1_out_pc", out_pc, 32'h10);
    check_output("t1_out_rs1val", out_rs1val, 32'hAA);
    check_output("t1_out_rs2val", out_rs2val, 32'h11);
    check_output("t1_out_ctrl", 32'(out_ctrl), 32'h1210);
    check_output("t1_out_rd", 32'(out_rd), 3);
    check_output("t1_occupancy", 32'(occupancy), 1);
    step();
    check_output("t1_drained", 32'(occupancy), 0);
    check_output("t1_forced_zero", out_pc, 0);

    // fill to DEPTH with out_ready low, then drain in order
    apply_stimulus(1, 32'h20, 0, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 32'h24, 0, 0, 0, 0, 0, 0);
    #1 check_output("t2_ready_second", 32'(in_ready), 1);
    step();
    apply_stimulus(1, 32'h28, 0, 0, 0, 0, 0, 0);
    #1 check_output("t2_full_ready", 32'(in_ready), 0);
    check_output("t2_full_occ", 32'(occupancy), 2);
    out_ready = 1;
    #1 check_output("t2_no_ready_path", 32'(in_ready), 0);
    check_output("t2_head0", out_pc, 32'h20);
    step();
    check_output("t2_head1", out_pc, 32'h24);
    check_output("t2_occ1", 32'(occupancy), 1);
    step();
    check_output("t2_head2", out_pc, 32'h28);
    check_output("t2_occ_steady", 32'(occupancy), 1);
    in_pc = 32'h2C;
    step();
    check_output("t2_head3", out_pc, 32'h2C);
    in_valid = 0;
    step();
    check_output("t2_drained", 32'(occupancy), 0);

    // load rd=5 at head, consumer reads rs2=5
    apply_stimulus(1, 32'h30, 0, 0, 5'd5, 1, 0, 0);
    step();
    check_output("t3_load_in", 32'(occupancy), 1);
    apply_stimulus(1, 32'h34, 5'd1, 5'd5, 5'd6, 0, 0, 0);
    #1 check_output("t3_stall", 32'(hazard_stall), 1);
    check_output("t3_stall_ready", 32'(in_ready), 0);
    step();
    check_output("t3_bubble_occ", 32'(occupancy), 1);
    check_output("t3_bubble_head", out_pc, 32'h30);
    out_ready = 1;
    #1 check_output("t3_head_is_load", 32'(out_is_load), 1);
    check_output("t3_stall_held", 32'(hazard_stall), 1);
    step();
    check_output("t3_stall_clear", 32'(hazard_stall), 0);
    check_output("t3_ready_after", 32'(in_ready), 1);
    check_output("t3_empty_after", 32'(occupancy), 0);
    step();
    check_output("t3_accepted_pc", out_pc, 32'h34);
    check_output("t3_accepted_valid", 32'(out_valid), 1);
    in_valid = 0;
    step();
`ifdef IDEX_BUBBLE_CNT_EN
    check_output("t3_bubble_cnt", bubble_cnt, 2);
`endif

    // load to x0 never stalls
    apply_stimulus(1, 32'h40, 0, 0, 5'd0, 1, 0, 0);
    step();
    apply_stimulus(1, 32'h44, 5'd0, 5'd0, 5'd7, 0, 0, 0);
    #1 check_output("t3_x0_no_stall", 32'(hazard_stall), 0);
    check_output("t3_x0_ready", 32'(in_ready), 1);
    step();
    check_output("t3_x0_occ", 32'(occupancy), 2);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    check_output("t3_x0_drained", 32'(occupancy), 0);

    // flush with head consume and an incoming beat
    apply_stimulus(1, 32'h50, 0, 0, 0, 0, 0, 0);
    step();
    in_pc = 32'h54;
    step();
    check_output("t4_occ_pre", 32'(occupancy), 2);
    apply_stimulus(1, 32'h58, 0, 0, 0, 0, 1, 1);
    #1 check_output("t4_flush_ready", 32'(in_ready), 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("t4_out_valid", 32'(out_valid), 0);
    check_output("t4_occ_post", 32'(occupancy), 0);
    check_output("t4_out_pc", out_pc, 0);
`ifdef IDEX_BUBBLE_CNT_EN
    check_output("t4_flush_cnt", flush_cnt, 1);
`endif
    apply_stimulus(1, 32'h60, 0, 0, 0, 0, 0, 0);
    step();
    check_output("t4_resume_pc", out_pc, 32'h60);
    check_output("t4_resume_occ", 32'(occupancy), 1);

    // async reset while two entries are held
    in_pc = 32'h70;
    step();
    in_valid = 0;
    check_output("t5_occ_pre", 32'(occupancy), 2);
    #2 RSTB = 1'b0;
    #1 check_output("t5_out_valid", 32'(out_valid), 0);
    check_output("t5_out_pc", out_pc, 0);
    check_output("t5_occ", 32'(occupancy), 0);
`ifdef IDEX_BUBBLE_CNT_EN
    check_output("t5_bubble_cnt", bubble_cnt, 0);
    check_output("t5_flush_cnt", flush_cnt, 0);
`endif
    #1 RSTB = 1'b1;
    step();

    // DEPTH=4 traffic with random consumer; queue is the reference
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 20 && cyc < 400) begin
      ordy4 = 1'($urandom_range(0, 1));
      v4    = (sent < 20);
      pc4   = 32'h100 + 32'(sent) * 4;
      #1;
      check_output("t6_occ_model", 32'(occ4), 32'(q.size()));
      hs_in = v4 & ready4;
      if (valid4 && ordy4) begin
        check_output("t6_order", opc4, 32'(q.pop_front()));
        got++;
      end
      step();
      if (hs_in) begin
        q.push_back(32'h100 + sent * 4);
        sent++;
      end
      cyc++;
    end
    v4 = 0;
    ordy4 = 0;
    check_output("t6_all_received", 32'(got), 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
